// File: rtl/simon_pkg.sv
// Shared definitions for the Simon pattern playback sequencer.
package simon_pkg;

   localparam int SIMON_ADDR_W_DEFAULT = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHOW  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/simon_tick_timer.sv
// Down-counting dwell timer: loads on request, stops at zero without wrapping.
module simon_tick_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/simon_playback_sequencer.sv
// Plays stored LED patterns from a synchronous-read memory, one entry at a time,
// each lit for ON_CYCLES then blanked for OFF_CYCLES.
module simon_playback_sequencer
   import simon_pkg::*;
#(
   parameter int ADDR_W     = SIMON_ADDR_W_DEFAULT,
   parameter int ON_CYCLES  = 3,
   parameter int OFF_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   count,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [3:0]        rd_data,
   output logic [3:0]        pattern_leds,
   output logic              busy,
   output logic              done
);

   localparam int DWELL_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW        = $clog2(DWELL_MAX + 1);

   // The timer reads zero in the last cycle of a phase, so phases load length-1.
   localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LOAD = TW'((OFF_CYCLES > 0) ? OFF_CYCLES - 1 : 0);

   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state, state_n;
   logic [ADDR_W:0]   index;
   logic [ADDR_W:0]   cnt_lat;
   logic [3:0]        hold;
   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_zero;
   logic              last;

   function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W:0] c);
      return (c > FULL) ? FULL : c;
   endfunction

   assign last = (index == cnt_lat - ONE);

   simon_tick_timer #(
      .W(TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n = (sat_count(count) != '0) ? ST_FETCH : ST_DONE;
            end
         end
         ST_FETCH: state_n = ST_LOAD;
         ST_LOAD: begin
            state_n  = ST_SHOW;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
         end
         ST_SHOW: begin
            if (tmr_zero) begin
               if (OFF_CYCLES > 0) begin
                  state_n  = ST_GAP;
                  tmr_load = 1'b1;
                  tmr_val  = OFF_LOAD;
               end else begin
                  state_n = last ? ST_DONE : ST_FETCH;
               end
            end
         end
         ST_GAP: begin
            if (tmr_zero) begin
               state_n = last ? ST_DONE : ST_FETCH;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      // Abort only redirects the next state; the current cycle's outputs stand.
      if (abort && state != ST_IDLE) begin
         state_n = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         index   <= '0;
         cnt_lat <= '0;
         hold    <= '0;
      end else begin
         if (state == ST_IDLE && start) begin
            index   <= '0;
            cnt_lat <= sat_count(count);
         end else if ((state == ST_SHOW || state == ST_GAP) && state_n == ST_FETCH) begin
            index <= index + ONE;
         end
         if (state == ST_LOAD) begin
            hold <= rd_data;
         end
      end
   end

   assign rd_en        = (state == ST_FETCH);
   assign rd_addr      = (state == ST_FETCH) ? index[ADDR_W-1:0] : '0;
   assign pattern_leds = (state == ST_SHOW) ? hold : 4'h0;
   assign busy         = (state != ST_IDLE);
   assign done         = (state == ST_DONE);

endmodule

// File: doc/simon_playback_sequencer.md
SIMON_PLAYBACK_SEQUENCER -- requirements
Module: simon_playback_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6: pattern-memory address width; up to 2^ADDR_W stored entries.
REQ-002 Parameter ON_CYCLES, default 3: cycles each entry is lit; legal range >= 1.
REQ-003 Parameter OFF_CYCLES, default 2: blank cycles after each entry; legal range >= 0.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  playback request, sampled only in IDLE.
REQ-007 abort  in  1  terminate playback, sampled only when busy.
REQ-008 count  in  ADDR_W+1  number of entries to play, sampled with accepted start.
REQ-009 rd_en  out  1  pattern-memory read strobe.
REQ-010 rd_addr  out  ADDR_W  read address; 0 when rd_en low.
REQ-011 rd_data  in  4  read data, valid exactly one cycle after rd_en.
REQ-012 pattern_leds  out  4  displayed pattern; 0 when not showing.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse on normal completion.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, LOAD, SHOW, GAP and DONE.
REQ-016 IDLE & start: latch count (values above 2^ADDR_W saturate to 2^ADDR_W) and clear index; next state FETCH if latched count != 0, else DONE.
REQ-017 FETCH (1 cycle): rd_en=1, rd_addr=index; next LOAD.
REQ-018 LOAD (1 cycle): capture rd_data into the LED hold register; pattern_leds=0; next SHOW.
REQ-019 SHOW lasts exactly ON_CYCLES cycles with pattern_leds=hold register; next GAP, or skip GAP when OFF_CYCLES=0.
REQ-020 GAP lasts exactly OFF_CYCLES cycles with pattern_leds=0.
REQ-021 At the end of each entry, the FSM SHALL go to DONE if index == latched count-1; otherwise it SHALL increment index and go to FETCH.
REQ-022 DONE (1 cycle): done=1; next IDLE.
REQ-023 Timing: for start in cycle 0, done SHALL be high in cycle 1+N*(2+ON_CYCLES+OFF_CYCLES), where N is the latched count.
REQ-024 start while busy SHALL be ignored, and changes on count while busy SHALL be ignored.
REQ-025 abort in any busy state: next state IDLE, with pattern_leds=0, rd_en=0 and no done pulse; abort in IDLE SHALL be ignored.
REQ-026 Simultaneous abort and FSM exit from DONE: the done pulse of that cycle SHALL still be emitted, because abort has effect only on the next state.
REQ-027 The dwell counter SHALL be $clog2(max(ON_CYCLES,OFF_CYCLES)+1) bits wide, SHALL load on state entry and SHALL count down without wrap-around.
REQ-028 The index SHALL be ADDR_W+1 bits wide internally, and the low ADDR_W bits SHALL drive rd_addr; with a full count of 2^ADDR_W, the last address is 2^ADDR_W-1 and no wrap occurs.

Reset
REQ-029 rst SHALL force IDLE, index=0, hold register=0, latched count=0, and dwell counter=0.
REQ-030 In the cycle after rst, the outputs SHALL be rd_en=0, rd_addr=0, pattern_leds=0, busy=0 and done=0.
REQ-031 rst mid-playback SHALL abandon playback with no done pulse, and rst SHALL take priority over start and abort.

Structure
REQ-032 The shared package simon_pkg SHALL hold the FSM state encoding constants and the default ADDR_W.
REQ-033 The dwell counter SHALL be one sub-module, simon_tick_timer, with load, load value, and zero flag.
REQ-034 All outputs SHALL be registered or SHALL be decoded only from state and registers, with no combinational path from any input to any output.

Verification (ADDR_W=4, ON_CYCLES=3, OFF_CYCLES=2)
REQ-035 Assert rst for 2 cycles -> all outputs SHALL be 0 in the following cycle.
REQ-036 Memory {0x1,0x8}, count=2, start at cycle 0 -> expected response:
- rd_en/addr0 in cycle 1; leds=0x1 in cycles 3-5; leds=0 in cycles 6-7;
- rd_en/addr1 in cycle 8; leds=0x8 in cycles 10-12;
- done in cycle 15; busy in cycles 1-15.
REQ-037 count=0, start -> done in cycle 1, with rd_en never asserted and busy high for cycle 1 only.
REQ-038 count=2, abort in cycle 4 -> in cycle 5, busy=0 and leds=0, and done SHALL never pulse.
REQ-039 count=1, start held high, and count changed to 5 during playback -> one entry played, done in cycle 8, then a new playback SHALL start from cycle 9 with latched count 5.
REQ-040 count=16 (full depth), with rst pulsed in cycle 10 -> IDLE in cycle 11; a fresh start with count=16 SHALL read addresses 0..15 in order, with done in cycle 1+16*7.
